// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

    localparam int XLEN = 32;

    // Canonical no-op word (addi x0, x0, 0), handy as filler in benches.
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FC_IDLE  = 2'd0,
        FC_FETCH = 2'd1,
        FC_DRAIN = 2'd2
    } fc_state_e;

    // One queued fetch result: the word and the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry fetch queue toward decode. Entry 0 is always the head, so the
// head outputs come straight from flops with no read-pointer mux.
module fetch_buf
    import fetch_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_pc,
    input  logic [XLEN-1:0] push_instr,
    output logic [1:0]      count,
    output logic            head_valid,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_instr
);

    fetch_entry_t e0_q, e0_d;
    fetch_entry_t e1_q, e1_d;
    fetch_entry_t new_entry;
    logic [1:0]   count_q, count_d;
    logic         valid_q, valid_d;

    assign new_entry = '{pc: push_pc, instr: push_instr};

    // Next queue contents: flush wins, otherwise shift on pop and append on push.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) e0_d = new_entry;
                    else                 e1_d = new_entry;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    e0_d    = e1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains.
                    if (count_q == 2'd2) begin
                        e0_d = e1_q;
                        e1_d = new_entry;
                    end else begin
                        e0_d = new_entry;
                    end
                end
                default: ;
            endcase
        end
        valid_d = (count_d != 2'd0);
    end

    // Queue storage and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign count      = count_q;
    assign head_valid = valid_q;
    assign head_pc    = e0_q.pc;
    assign head_instr = e0_q.instr;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one request at a time to
// a variable-latency instruction memory, queues returned words for decode
// and redirects on taken jumps, draining any stale in-flight response.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jump,
    input  logic [31:0] jump_base,
    input  logic [31:0] pc_imm,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc
);

    fc_state_e       state_q, state_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] pc_q, pc_d;

    logic            jump_act;
    logic            req_pending;
    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] pc_next_seq;

    logic            buf_push;
    logic            buf_pop;
    logic            buf_flush;
    logic [1:0]      buf_count;
    logic [1:0]      count_after;

    // Jumps are ignored until the sequencer has left IDLE.
    assign jump_act    = jump && (state_q != FC_IDLE);
    assign req_pending = req_q && !imem_ack;
    assign jump_target = word_align(jump_base + pc_imm);
    assign pc_next_seq = pc_q + XLEN'(PC_STEP);

    // A flushing jump cancels any pop decode attempts in the same cycle.
    assign buf_flush   = jump_act;
    assign buf_pop     = instr_valid && instr_ready && !jump_act;
    // Occupancy once this cycle's ack is pushed; decides back-to-back issue.
    assign count_after = buf_count + 2'd1 - {1'b0, buf_pop};

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FC_IDLE;
        else        state_q <= state_d;
    end

    // Next state: a jump with a request still in flight must wait out its ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FC_IDLE:  state_d = FC_FETCH;
            FC_FETCH: if (jump_act && req_pending) state_d = FC_DRAIN;
            FC_DRAIN: if (imem_ack) state_d = FC_FETCH;
            default:  state_d = FC_IDLE;
        endcase
    end

    // Request, address, PC and queue-push decisions for this cycle.
    always_comb begin
        req_d    = req_q;
        addr_d   = addr_q;
        pc_d     = pc_q;
        buf_push = 1'b0;
        case (state_q)
            FC_IDLE: begin
                req_d = 1'b0;
            end
            FC_FETCH: begin
                if (jump_act) begin
                    pc_d = jump_target;
                    // An un-acked request stays on the bus (DRAIN); an acked one is dropped.
                    if (!req_pending) req_d = 1'b0;
                end else if (req_q && imem_ack) begin
                    buf_push = 1'b1;
                    pc_d     = pc_next_seq;
                    req_d    = (count_after < 2'd2);
                    addr_d   = pc_next_seq;
                end else if (!req_q && (buf_count < 2'd2)) begin
                    req_d  = 1'b1;
                    addr_d = pc_q;
                end
            end
            FC_DRAIN: begin
                if (jump_act) pc_d = jump_target;
                // Stale response is discarded; reissue from the new PC next cycle.
                if (imem_ack) req_d = 1'b0;
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    // Request, address and PC registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q  <= 1'b0;
            addr_q <= '0;
            pc_q   <= RESET_PC;
        end else begin
            req_q  <= req_d;
            addr_q <= addr_d;
            pc_q   <= pc_d;
        end
    end

    fetch_buf u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (buf_push),
        .pop        (buf_pop),
        .flush      (buf_flush),
        .push_pc    (addr_q),
        .push_instr (imem_rdata),
        .count      (buf_count),
        .head_valid (instr_valid),
        .head_pc    (instr_pc),
        .head_instr (instr)
    );

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl. The memory model returns ~addr as the
// instruction word after a programmable number of cycles.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        jump;
    logic [31:0] jump_base;
    logic [31:0] pc_imm;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_lat  = 1;
    int mem_cnt  = 0;
    int push_full_cnt = 0;

    fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .jump        (jump),
        .jump_base   (jump_base),
        .pc_imm      (pc_imm),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    // Memory: ack mem_lat cycles after the request is first seen.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (!reset) begin
                mem_cnt = 0;
            end else if (imem_req) begin
                mem_cnt++;
                if (mem_cnt > mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = ~imem_addr;
                    mem_cnt    = 0;
                end
            end
        end
    end

    // A push into a full queue must never happen.
    always @(posedge clk) begin
        if (reset && dut.buf_push && (dut.buf_count == 2'd2))
            push_full_cnt <= push_full_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        jump        = 1'b0;
        jump_base   = '0;
        pc_imm      = '0;
        instr_ready = 1'b0;
        step();
        step();

        // Reset state
        check_eq("rst_req",      {31'd0, imem_req},    32'd0);
        check_eq("rst_addr",     imem_addr,            32'd0);
        check_eq("rst_valid",    {31'd0, instr_valid}, 32'd0);
        check_eq("rst_instr",    instr,                32'd0);
        check_eq("rst_instr_pc", instr_pc,             32'd0);
        check_eq("rst_pc",       pc,                   32'd0);

        // Sequential fetch, 1-cycle memory, decode always ready
        instr_ready = 1'b1;
        mem_lat     = 1;
        reset       = 1'b1;
        step();
        check_eq("t1_idle_req", {31'd0, imem_req}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("t1_req",  {31'd0, imem_req}, 32'd1);
            check_eq("t1_addr", imem_addr, 32'(4 * k));
            if (k > 0) begin
                check_eq("t1_valid",    {31'd0, instr_valid}, 32'd1);
                check_eq("t1_instr_pc", instr_pc, 32'(4 * (k - 1)));
                check_eq("t1_instr",    instr, ~32'(4 * (k - 1)));
            end else begin
                check_eq("t1_first_valid", {31'd0, instr_valid}, 32'd0);
            end
            step();
            check_eq("t1_gap_valid", {31'd0, instr_valid}, 32'd0);
            check_eq("t1_hold_addr", imem_addr, 32'(4 * k));
        end

        // Decode stalled: queue fills with two words, then drains in order
        reset       = 1'b0;
        instr_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i >= 6) check_eq("t2_req_low_full", {31'd0, imem_req}, 32'd0);
        end
        check_eq("t2_head_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("t2_head_pc",    instr_pc, 32'h0);
        check_eq("t2_head_instr", instr,    32'hFFFF_FFFF);
        check_eq("t2_pc",         pc,       32'h8);
        instr_ready = 1'b1;
        step();
        check_eq("t2_second_pc",    instr_pc, 32'h4);
        check_eq("t2_second_instr", instr,    32'hFFFF_FFFB);
        check_eq("t2_second_req",   {31'd0, imem_req}, 32'd0);
        step();
        check_eq("t2_resume_req",  {31'd0, imem_req}, 32'd1);
        check_eq("t2_resume_addr", imem_addr, 32'h8);
        check_eq("t2_empty",       {31'd0, instr_valid}, 32'd0);
        step();
        step();
        check_eq("t2_third_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("t2_third_pc",    instr_pc, 32'h8);

        // Jump while a slow request for 0x14 is outstanding -> DRAIN
        reset = 1'b0;
        step();
        step();
        reset       = 1'b1;
        instr_ready = 1'b1;
        mem_lat     = 1;
        repeat (12) step();
        check_eq("t3_req_14", imem_addr, 32'h14);
        mem_lat = 3;
        step();
        jump      = 1'b1;
        jump_base = 32'h10;
        pc_imm    = 32'hFFFF_FFF0;
        step();
        jump = 1'b0;
        check_eq("t3_drain_req",   {31'd0, imem_req}, 32'd1);
        check_eq("t3_drain_addr",  imem_addr, 32'h14);
        check_eq("t3_drain_pc",    pc, 32'h0);
        check_eq("t3_drain_valid", {31'd0, instr_valid}, 32'd0);
        step();
        check_eq("t3_ack_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("t3_ack_req",   {31'd0, imem_req}, 32'd1);
        step();
        check_eq("t3_post_req",   {31'd0, imem_req}, 32'd0);
        check_eq("t3_post_valid", {31'd0, instr_valid}, 32'd0);
        mem_lat = 1;
        step();
        check_eq("t3_new_req",  {31'd0, imem_req}, 32'd1);
        check_eq("t3_new_addr", imem_addr, 32'h0);
        step();
        check_eq("t3_no_stale", {31'd0, instr_valid}, 32'd0);
        step();
        check_eq("t3_tgt_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("t3_tgt_pc",    instr_pc, 32'h0);
        check_eq("t3_tgt_instr", instr,    32'hFFFF_FFFF);

        // Jump on the ack cycle with a word queued; target 0x102 aligns to 0x100
        instr_ready = 1'b0;
        step();
        check_eq("t4_queued_pc", instr_pc, 32'h0);
        check_eq("t4_ack_addr",  imem_addr, 32'h4);
        jump      = 1'b1;
        jump_base = 32'h100;
        pc_imm    = 32'h2;
        step();
        jump = 1'b0;
        check_eq("t4_flushed", {31'd0, instr_valid}, 32'd0);
        check_eq("t4_req_low", {31'd0, imem_req}, 32'd0);
        check_eq("t4_pc",      pc, 32'h100);
        instr_ready = 1'b1;
        step();
        check_eq("t4_req",  {31'd0, imem_req}, 32'd1);
        check_eq("t4_addr", imem_addr, 32'h100);
        step();
        step();
        check_eq("t4_tgt_pc",    instr_pc, 32'h100);
        check_eq("t4_tgt_instr", instr,    32'hFFFF_FEFF);

        // Jump to the top word, then sequential wrap to 0
        jump      = 1'b1;
        jump_base = 32'hFFFF_FFF8;
        pc_imm    = 32'h4;
        step();
        jump = 1'b0;
        check_eq("t5_flush_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("t5_pc_top",      pc, 32'hFFFF_FFFC);
        step();
        step();
        check_eq("t5_req_top", imem_addr, 32'hFFFF_FFFC);
        step();
        step();
        check_eq("t5_top_pc",    instr_pc,  32'hFFFF_FFFC);
        check_eq("t5_top_instr", instr,     32'h0000_0003);
        check_eq("t5_wrap_addr", imem_addr, 32'h0);
        check_eq("t5_wrap_pc",   pc,        32'h0);

        // Reset mid-request: outputs drop asynchronously, restart at RESET_PC
        instr_ready = 1'b0;
        mem_lat     = 20;
        step();
        step();
        check_eq("t6_pre_req",   {31'd0, imem_req},    32'd1);
        check_eq("t6_pre_valid", {31'd0, instr_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("t6_async_req",   {31'd0, imem_req},    32'd0);
        check_eq("t6_async_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("t6_async_instr", instr, 32'd0);
        check_eq("t6_async_pc",    pc,    32'd0);
        step();
        step();
        reset       = 1'b1;
        mem_lat     = 1;
        instr_ready = 1'b1;
        step();
        step();
        check_eq("t6_restart_req",  {31'd0, imem_req}, 32'd1);
        check_eq("t6_restart_addr", imem_addr, 32'h0);
        step();
        step();
        check_eq("t6_restart_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("t6_restart_pc",    instr_pc, 32'h0);

        check_eq("no_push_when_full", 32'(push_full_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer owning the program counter. It issues one request at a time to a variable-latency instruction memory over a req/ack handshake and buffers returned words in a 2-entry queue toward decode (valid/ready). It applies taken jumps (base + immediate) by flushing the queue and discarding any in-flight stale response. It replaces free-running pc+4 sequencing whenever memory or decode can stall.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, sequential increment in bytes

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
jump  in  1  taken-jump strobe, single cycle
jump_base  in  32  PC of the jumping instruction
pc_imm  in  32  signed jump offset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address, word aligned
imem_ack  in  1  memory response valid, one cycle per request
imem_rdata  in  32  returned instruction word
instr_valid  out  1  queue head valid toward decode
instr_ready  in  1  decode accepts head this cycle
instr  out  32  head instruction word
instr_pc  out  32  address of head instruction
pc  out  32  next address to fetch

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=0, queue count=0, instr_valid=0, instr=0, instr_pc=0. An outstanding request is abandoned; memory tolerates this.
- States: IDLE, FETCH, DRAIN (2-bit encoding).
- IDLE: first clock after reset release -> FETCH.
- FETCH: imem_req=1 with imem_addr=pc, only while count<2 at issue. Once asserted, req and addr are held stable until imem_ack. At most one request outstanding.
- On imem_ack in FETCH with no jump:
  - push {imem_rdata, imem_addr} into the queue.
  - pc <= pc+PC_STEP.
  - The next request issues the following cycle if post-update count<2.
- Queue pop: instr_valid && instr_ready. Push and pop in the same cycle leave count unchanged. Push at count==2 is impossible by construction; the bench asserts this.
- Outputs instr/instr_pc/instr_valid are registered from the queue head; no combinational path from imem_* or instr_ready to outputs.
- Jump (highest priority, any state except IDLE):
  - pc <= (jump_base+pc_imm) & ~32'h3; the sum is modulo 2^32 and wraps.
  - Queue flushed: count=0 and instr_valid=0 next cycle. A same-cycle pop is ignored.
  - Request outstanding and no imem_ack this cycle -> DRAIN.
  - Otherwise (no request, or ack this cycle) -> FETCH; any same-cycle ack data is discarded.
- DRAIN: keep imem_req/imem_addr of the stale request. On imem_ack, discard data, deassert req, go to FETCH; new request issues next cycle at the updated pc. A further jump in DRAIN updates pc and stays in DRAIN.
- Jump in IDLE is ignored.
- pc wraps 32'hFFFF_FFFC -> 32'h0 on sequential step.
- Latency: best case (ack one cycle after req), an instruction is presented on instr_valid 2 cycles after req asserts. Throughput is one instruction per 2 cycles; one outstanding request only.

Decomposition:
- Shared package/defines: state encodings FC_IDLE/FC_FETCH/FC_DRAIN, XLEN=32, NOP encoding for bench.
- Sub-module fetch_buf: 2-entry synchronous FIFO of {pc, instr}; ports push, pop, flush, count, head outputs; async active-low reset.

Test Plan:
- Reset release, imem acks 1 cycle after each req, ready=1 -> imem_addr sequence 0,4,8,C; instr_pc matches; instr_valid 2 cycles after each req.
- instr_ready=0 for 10 cycles -> exactly 2 words queued, imem_req low while count==2; releasing ready drains PC 0 then 4 and fetching resumes at 8.
- Jump with jump_base=0x10, pc_imm=0xFFFFFFF0 while a req for 0x14 is outstanding (ack 3 cycles later) -> DRAIN, stale word never presented, next req addr=0x0.
- Jump in the same cycle as imem_ack -> acked word dropped, queue empty next cycle, req to target the following cycle.
- Jump target 0x102 -> pc=0x100; sequential from 0xFFFFFFFC wraps to 0x0.
- reset asserted mid-request (req high, no ack) -> imem_req, instr_valid drop asynchronously; after release, fetch restarts at RESET_PC.
